// File: rtl/ct_f_spsram_64x108_arb.sv
// Round-robin write/read arbiter driving one 64x108 single-port SRAM, with an optional
// post-reset zeroing sweep compiled in by defining CT_SPSRAM_ARB_INIT_EN.
module ct_f_spsram_64x108_arb #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 108,
  parameter int LANE_WIDTH = 27
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [3:0]            wr_lane,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q
);

  localparam int NUM_LANES = 4;

  // Handshake: a requester raises *_req with stable address/data and holds it until the
  // matching *_gnt is high; *_gnt is combinational, and the transfer happens in the cycle
  // where req and gnt are both high (the SRAM samples the pins at the next rising edge).

  logic last_winner_q, last_winner_d;  // 1: write won last, 0: read won last
  logic rd_vld_q, rd_vld_d;
  logic in_init;
  logic run_ok;
  logic [DATA_WIDTH-1:0] lane_wen;

`ifdef CT_SPSRAM_ARB_INIT_EN
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_ptr_q, init_ptr_d;

  assign in_init   = (state_q == ST_INIT);
  assign init_done = (state_q == ST_RUN);
`else
  assign in_init   = 1'b0;
  assign init_done = 1'b1;
`endif

  // Grants and pins are held idle while RST is high so the macro sees no access during reset.
  assign run_ok = ~RST & ~in_init;
  assign rd_gnt = run_ok & rd_req & (~wr_req | last_winner_q);
  assign wr_gnt = run_ok & wr_req & (~rd_req | ~last_winner_q);

  always_comb begin
    lane_wen = '1;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_wen[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{~wr_lane[i]}};
    end
  end

  always_comb begin
    CEN  = 1'b1;
    GWEN = 1'b1;
    WEN  = '1;
    A    = '0;
    D    = '0;
    if (!RST) begin
`ifdef CT_SPSRAM_ARB_INIT_EN
      if (in_init) begin
        CEN  = 1'b0;
        GWEN = 1'b0;
        WEN  = '0;
        A    = init_ptr_q;
      end
`endif
      if (wr_gnt) begin
        CEN  = 1'b0;
        GWEN = 1'b0;
        WEN  = lane_wen;
        A    = wr_addr;
        D    = wr_data;
      end else if (rd_gnt) begin
        CEN  = 1'b0;
        A    = rd_addr;
      end
    end
  end

  always_comb begin
    last_winner_d = last_winner_q;
    if (wr_gnt) begin
      last_winner_d = 1'b1;
    end else if (rd_gnt) begin
      last_winner_d = 1'b0;
    end
    rd_vld_d = rd_gnt;
  end

`ifdef CT_SPSRAM_ARB_INIT_EN
  // The pointer wraps to 0 on its own as the last entry is written.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    if (state_q == ST_INIT) begin
      init_ptr_d = init_ptr_q + 1'b1;
      if (init_ptr_q == '1) begin
        state_d = ST_RUN;
      end
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_winner_q <= 1'b1;
      rd_vld_q      <= 1'b0;
`ifdef CT_SPSRAM_ARB_INIT_EN
      state_q       <= ST_INIT;
      init_ptr_q    <= '0;
`endif
    end else begin
      last_winner_q <= last_winner_d;
      rd_vld_q      <= rd_vld_d;
`ifdef CT_SPSRAM_ARB_INIT_EN
      state_q       <= state_d;
      init_ptr_q    <= init_ptr_d;
`endif
    end
  end

  assign rd_vld  = rd_vld_q;
  assign rd_data = rd_vld_q ? Q : '0;

endmodule

// File: tb/tb_ct_f_spsram_64x108_arb.sv
// Bench for ct_f_spsram_64x108_arb: behavioural SRAM macro, reference memory and
// round-robin model, directed scenarios and a randomized request stream.
module tb_ct_f_spsram_64x108_arb;

  localparam int AW = 6;
  localparam int DW = 108;
  localparam int LW = 27;
  localparam logic [DW-1:0] ONES = '1;
`ifdef CT_SPSRAM_ARB_INIT_EN
  localparam logic INIT_DONE_IN_RST = 1'b0;
`else
  localparam logic INIT_DONE_IN_RST = 1'b1;
`endif

  logic          CLK, RST;
  logic          wr_req, rd_req, wr_gnt, rd_gnt, rd_vld, init_done, CEN, GWEN;
  logic [AW-1:0] wr_addr, rd_addr, A;
  logic [DW-1:0] wr_data, rd_data, WEN, D, Q;
  logic [3:0]    wr_lane;

  int checks_total;
  int checks_passed;

  // reference model
  logic [DW-1:0] ref_mem [64];
  logic          ref_last;  // 1 when the write side won the last arbitration
  logic [DW-1:0] exp_q [$];

  ct_f_spsram_64x108_arb dut (
    .CLK(CLK), .RST(RST),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_lane(wr_lane), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_data(rd_data),
    .init_done(init_done), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D), .Q(Q)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] rand_word();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // Behavioural macro: scrambled by reset when the sweep exists, cleared otherwise.
  logic [DW-1:0] sram [64];
  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 64; i++) begin
`ifdef CT_SPSRAM_ARB_INIT_EN
        sram[i] <= rand_word();
`else
        sram[i] <= '0;
`endif
      end
    end else if (!CEN) begin
      if (!GWEN) sram[A] <= (sram[A] & WEN) | (D & ~WEN);
      else Q <= sram[A];
    end
  end

  function automatic void model_reset();
    ref_last = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
  endfunction

  function automatic void model_arb(input logic wq, input logic rq, output logic ew, output logic er);
    ew = 1'b0;
    er = 1'b0;
    if (wq && rq) begin
      if (ref_last) er = 1'b1;
      else ew = 1'b1;
    end else if (wq) ew = 1'b1;
    else if (rq) er = 1'b1;
    if (ew) ref_last = 1'b1;
    if (er) ref_last = 1'b0;
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] l);
    for (int i = 0; i < 4; i++) if (l[i]) ref_mem[a][i*LW +: LW] = d[i*LW +: LW];
  endfunction

  function automatic logic [DW-1:0] wen_for(input logic [3:0] l);
    logic [DW-1:0] w;
    w = '1;
    for (int i = 0; i < 4; i++) if (l[i]) w[i*LW +: LW] = '0;
    return w;
  endfunction

  // driver tasks
  task automatic drive(input logic wq, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [3:0] wl, input logic rq, input logic [AW-1:0] ra);
    wr_req = wq; wr_addr = wa; wr_data = wd; wr_lane = wl; rd_req = rq; rd_addr = ra;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 4'h0, 1'b0, '0);
  endtask

  task automatic test_reset();
    @(negedge CLK); RST = 1'b1; drive(1'b1, 6'd1, rand_word(), 4'hF, 1'b1, 6'd2);
    @(negedge CLK); #1;
    checks_total++; if ({wr_gnt, rd_gnt} !== 2'b00) $display("FAIL reset_gnt: got %b want 00", {wr_gnt, rd_gnt}); else checks_passed++;
    checks_total++; if ({CEN, GWEN, A} !== {1'b1, 1'b1, 6'd0}) $display("FAIL reset_pins: CEN/GWEN/A got %b want 11000000", {CEN, GWEN, A}); else checks_passed++;
    checks_total++; if ({WEN, D} !== {ONES, {DW{1'b0}}}) $display("FAIL reset_wen_d: WEN=%h D=%h", WEN, D); else checks_passed++;
    checks_total++; if ({rd_vld, rd_data} !== {1'b0, {DW{1'b0}}}) $display("FAIL reset_rd: rd_vld=%b rd_data=%h want 0", rd_vld, rd_data); else checks_passed++;
    checks_total++; if (init_done !== INIT_DONE_IN_RST) $display("FAIL reset_init_done: got %b want %b", init_done, INIT_DONE_IN_RST); else checks_passed++;
    idle();
    model_reset();
  endtask

  // Entered with RST high; releases it with a read of entry 0 held.
  task automatic test_init_sweep();
    logic ew, er;
    @(negedge CLK); RST = 1'b0; drive(1'b0, '0, '0, 4'h0, 1'b1, 6'd0);
    model_reset();
`ifdef CT_SPSRAM_ARB_INIT_EN
    for (int c = 0; c < 64; c++) begin
      #1;
      checks_total++;
      if ({CEN, GWEN, A, |WEN, |D, wr_gnt, rd_gnt, init_done, rd_vld} !== {2'b00, c[5:0], 6'b0})
        $display("FAIL sweep_cycle %0d: CEN=%b GWEN=%b A=%0d WEN=%h D=%h gnt=%b%b init_done=%b rd_vld=%b",
                 c, CEN, GWEN, A, WEN, D, wr_gnt, rd_gnt, init_done, rd_vld);
      else checks_passed++;
      @(negedge CLK);
    end
`endif
    #1;
    model_arb(1'b0, 1'b1, ew, er);
    checks_total++; if ({init_done, rd_gnt} !== 2'b11) $display("FAIL first_grant: init_done/rd_gnt got %b want 11", {init_done, rd_gnt}); else checks_passed++;
    checks_total++; if ({CEN, GWEN, A} !== {1'b0, 1'b1, 6'd0}) $display("FAIL first_grant_pins: got %b want 01000000", {CEN, GWEN, A}); else checks_passed++;
    @(negedge CLK); idle(); #1;
    checks_total++; if ({rd_vld, rd_data} !== {1'b1, {DW{1'b0}}}) $display("FAIL first_read: rd_vld=%b rd_data=%h want 1/0", rd_vld, rd_data); else checks_passed++;
  endtask

  task automatic test_write_read();
    logic ew, er;
    logic [DW-1:0] wd;
    wd = 108'hABC_DEF0_1234_5678_9ABC_DEF0_1234;
    @(negedge CLK); drive(1'b1, 6'd5, wd, 4'hF, 1'b0, '0); #1;
    model_arb(1'b1, 1'b0, ew, er); model_write(6'd5, wd, 4'hF);
    checks_total++; if ({wr_gnt, rd_gnt} !== 2'b10) $display("FAIL wr_gnt: got %b want 10", {wr_gnt, rd_gnt}); else checks_passed++;
    checks_total++; if ({CEN, GWEN, A, WEN, D} !== {2'b00, 6'd5, {DW{1'b0}}, wd}) $display("FAIL wr_pins: A=%0d WEN=%h D=%h CEN=%b GWEN=%b", A, WEN, D, CEN, GWEN); else checks_passed++;
    @(negedge CLK); drive(1'b0, '0, '0, 4'h0, 1'b1, 6'd5); #1;
    model_arb(1'b0, 1'b1, ew, er);
    checks_total++; if ({rd_gnt, rd_vld} !== 2'b10) $display("FAIL rd_gnt: rd_gnt/rd_vld got %b want 10", {rd_gnt, rd_vld}); else checks_passed++;
    checks_total++; if ({CEN, GWEN, A, WEN} !== {2'b01, 6'd5, ONES}) $display("FAIL rd_pins: CEN=%b GWEN=%b A=%0d WEN=%h", CEN, GWEN, A, WEN); else checks_passed++;
    @(negedge CLK); idle(); #1;
    checks_total++; if ({rd_vld, rd_data} !== {1'b1, ref_mem[5]}) $display("FAIL rd_data: rd_vld=%b rd_data=%h want 1/%h", rd_vld, rd_data, ref_mem[5]); else checks_passed++;
    checks_total++; if ({CEN, GWEN, A, WEN, D} !== {2'b11, 6'd0, ONES, {DW{1'b0}}}) $display("FAIL idle_pins: CEN=%b GWEN=%b A=%0d WEN=%h D=%h", CEN, GWEN, A, WEN, D); else checks_passed++;
    @(negedge CLK); #1;
    checks_total++; if ({rd_vld, rd_data} !== {1'b0, {DW{1'b0}}}) $display("FAIL rd_vld_pulse: rd_vld=%b rd_data=%h want 0/0", rd_vld, rd_data); else checks_passed++;
  endtask

  task automatic test_lane_mask();
    logic ew, er;
    @(negedge CLK); drive(1'b1, 6'd9, ONES, 4'b0101, 1'b0, '0); #1;
    model_arb(1'b1, 1'b0, ew, er); model_write(6'd9, ONES, 4'b0101);
    checks_total++; if (wr_gnt !== 1'b1) $display("FAIL lane_gnt: wr_gnt=%b want 1", wr_gnt); else checks_passed++;
    checks_total++; if (WEN !== {{LW{1'b1}}, {LW{1'b0}}, {LW{1'b1}}, {LW{1'b0}}}) $display("FAIL lane_wen: WEN=%h", WEN); else checks_passed++;
    @(negedge CLK); drive(1'b0, '0, '0, 4'h0, 1'b1, 6'd9); #1;
    model_arb(1'b0, 1'b1, ew, er);
    @(negedge CLK); idle(); #1;
    checks_total++;
    if ({rd_vld, rd_data} !== {1'b1, {LW{1'b0}}, {LW{1'b1}}, {LW{1'b0}}, {LW{1'b1}}})
      $display("FAIL lane_read: rd_vld=%b rd_data=%h", rd_vld, rd_data);
    else checks_passed++;
  endtask

  task automatic test_noop_write();
    logic ew, er;
    @(negedge CLK); drive(1'b1, 6'd3, 108'd7, 4'hF, 1'b0, '0); #1;
    model_arb(1'b1, 1'b0, ew, er); model_write(6'd3, 108'd7, 4'hF);
    checks_total++; if (wr_gnt !== 1'b1) $display("FAIL noop_setup_gnt: wr_gnt=%b want 1", wr_gnt); else checks_passed++;
    @(negedge CLK); drive(1'b1, 6'd3, ONES, 4'h0, 1'b0, '0); #1;
    model_arb(1'b1, 1'b0, ew, er); model_write(6'd3, ONES, 4'h0);
    checks_total++; if ({wr_gnt, CEN, GWEN} !== 3'b100) $display("FAIL noop_gnt: wr_gnt/CEN/GWEN got %b want 100", {wr_gnt, CEN, GWEN}); else checks_passed++;
    checks_total++; if (WEN !== ONES) $display("FAIL noop_wen: WEN=%h want all ones", WEN); else checks_passed++;
    // the no-op write still counts as a write win, so the read goes next
    @(negedge CLK); drive(1'b1, 6'd3, ONES, 4'h0, 1'b1, 6'd3); #1;
    model_arb(1'b1, 1'b1, ew, er);
    checks_total++; if ({rd_gnt, wr_gnt} !== 2'b10) $display("FAIL noop_last_winner: rd/wr gnt got %b want 10", {rd_gnt, wr_gnt}); else checks_passed++;
    @(negedge CLK); drive(1'b1, 6'd3, ONES, 4'h0, 1'b0, '0); #1;
    model_arb(1'b1, 1'b0, ew, er);
    checks_total++; if (wr_gnt !== 1'b1) $display("FAIL noop_second_gnt: wr_gnt=%b want 1", wr_gnt); else checks_passed++;
    checks_total++; if ({rd_vld, rd_data} !== {1'b1, 108'd7}) $display("FAIL noop_read: rd_vld=%b rd_data=%h want 1/7", rd_vld, rd_data); else checks_passed++;
    @(negedge CLK); idle();
  endtask

  task automatic test_contention();
    logic ew, er, prev_rd;
    logic [DW-1:0] wd, exp_d;
    @(negedge CLK); RST = 1'b1; idle();
    @(negedge CLK); RST = 1'b0; model_reset();
    for (int c = 0; c < 100 && init_done !== 1'b1; c++) @(negedge CLK);
    checks_total++; if (init_done !== 1'b1) $display("FAIL contention_init_timeout: init_done=%b want 1", init_done); else checks_passed++;
    wd = rand_word();
    prev_rd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge CLK);
      drive(1'b1, 6'd20, wd, 4'hF, 1'b1, 6'd21); #1;
      model_arb(1'b1, 1'b1, ew, er);
      checks_total++;
      if ({rd_gnt, wr_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) $display("FAIL contention_gnt %0d: rd/wr got %b", i, {rd_gnt, wr_gnt});
      else checks_passed++;
      checks_total++; if (rd_vld !== prev_rd) $display("FAIL contention_vld %0d: rd_vld=%b want %b", i, rd_vld, prev_rd); else checks_passed++;
      if (prev_rd) begin
        exp_d = exp_q.pop_front();
        checks_total++; if (rd_data !== exp_d) $display("FAIL contention_data %0d: rd_data=%h want %h", i, rd_data, exp_d); else checks_passed++;
      end
      if (ew) model_write(6'd20, wd, 4'hF);
      if (er) exp_q.push_back(ref_mem[21]);
      prev_rd = er;
    end
    @(negedge CLK); idle(); #1;
    checks_total++; if (rd_vld !== prev_rd) $display("FAIL contention_tail_vld: rd_vld=%b want %b", rd_vld, prev_rd); else checks_passed++;
  endtask

  task automatic test_random(input int n);
    logic          wq, rq, ew, er, prev_rd;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd, exp_d;
    logic [3:0]    wl;
    wq = 1'b0; rq = 1'b0; prev_rd = 1'b0;
    wa = '0; ra = '0; wd = '0; wl = 4'h0;
    exp_q.delete();
    for (int c = 0; c <= n; c++) begin
      @(negedge CLK);
      if (c < n && !wq && $urandom_range(0, 2) != 0) begin
        wq = 1'b1; wa = 6'($urandom_range(0, 15)); wd = rand_word(); wl = 4'($urandom_range(0, 15));
      end
      if (c < n && !rq && $urandom_range(0, 2) != 0) begin
        rq = 1'b1; ra = 6'($urandom_range(0, 15));
      end
      drive(wq, wa, wd, wl, rq, ra); #1;
      model_arb(wq, rq, ew, er);
      checks_total++; if ({wr_gnt, rd_gnt} !== {ew, er}) $display("FAIL rand_gnt %0d: wr/rd got %b want %b", c, {wr_gnt, rd_gnt}, {ew, er}); else checks_passed++;
      checks_total++; if (rd_vld !== prev_rd) $display("FAIL rand_vld %0d: rd_vld=%b want %b", c, rd_vld, prev_rd); else checks_passed++;
      exp_d = prev_rd ? exp_q.pop_front() : '0;
      checks_total++; if (rd_data !== exp_d) $display("FAIL rand_data %0d: rd_data=%h want %h", c, rd_data, exp_d); else checks_passed++;
      checks_total++;
      if (ew) begin
        if ({CEN, GWEN, A, D, WEN} !== {2'b00, wa, wd, wen_for(wl)}) $display("FAIL rand_wr_pins %0d: A=%0d D=%h WEN=%h", c, A, D, WEN);
        else checks_passed++;
        model_write(wa, wd, wl);
        wq = 1'b0;
      end else if (er) begin
        if ({CEN, GWEN, A, WEN} !== {2'b01, ra, ONES}) $display("FAIL rand_rd_pins %0d: CEN=%b GWEN=%b A=%0d WEN=%h", c, CEN, GWEN, A, WEN);
        else checks_passed++;
        exp_q.push_back(ref_mem[ra]);
        rq = 1'b0;
      end else begin
        if ({CEN, GWEN, A, WEN, D} !== {2'b11, 6'd0, ONES, {DW{1'b0}}}) $display("FAIL rand_idle_pins %0d: CEN=%b A=%0d", c, CEN, A);
        else checks_passed++;
      end
      prev_rd = er;
    end
    @(negedge CLK); idle(); #1;
    exp_d = prev_rd ? exp_q.pop_front() : '0;
    checks_total++; if ({rd_vld, rd_data} !== {prev_rd, exp_d}) $display("FAIL rand_drain: rd_vld=%b rd_data=%h want %b/%h", rd_vld, rd_data, prev_rd, exp_d); else checks_passed++;
  endtask

  task automatic test_reset_mid_run();
    logic ew, er;
    @(negedge CLK); drive(1'b0, '0, '0, 4'h0, 1'b1, 6'd4); #1;
    model_arb(1'b0, 1'b1, ew, er);
    checks_total++; if (rd_gnt !== 1'b1) $display("FAIL midrun_pre_gnt: rd_gnt=%b want 1", rd_gnt); else checks_passed++;
    @(negedge CLK); RST = 1'b1; drive(1'b1, 6'd4, rand_word(), 4'hF, 1'b1, 6'd4); #1;
    checks_total++; if ({wr_gnt, rd_gnt, CEN} !== 3'b001) $display("FAIL midrun_rst_gnt: wr/rd/CEN got %b want 001", {wr_gnt, rd_gnt, CEN}); else checks_passed++;
    model_reset();
    @(negedge CLK); RST = 1'b0; #1;
    checks_total++; if (rd_vld !== 1'b0) $display("FAIL midrun_vld_cleared: rd_vld=%b want 0", rd_vld); else checks_passed++;
`ifdef CT_SPSRAM_ARB_INIT_EN
    checks_total++;
    if ({init_done, rd_gnt, wr_gnt, CEN, GWEN, A} !== 11'b0)
      $display("FAIL midrun_restart: init_done=%b gnt=%b%b CEN=%b GWEN=%b A=%0d", init_done, rd_gnt, wr_gnt, CEN, GWEN, A);
    else checks_passed++;
    idle();
`else
    model_arb(1'b1, 1'b1, ew, er);
    checks_total++; if ({rd_gnt, wr_gnt} !== 2'b10) $display("FAIL midrun_priority: rd/wr got %b want 10", {rd_gnt, wr_gnt}); else checks_passed++;
    @(negedge CLK); idle(); #1;
    checks_total++; if ({rd_vld, rd_data} !== {1'b1, ref_mem[4]}) $display("FAIL midrun_read: rd_vld=%b rd_data=%h", rd_vld, rd_data); else checks_passed++;
`endif
  endtask

`ifdef CT_SPSRAM_ARB_INIT_EN
  task automatic test_reset_mid_sweep();
    @(negedge CLK); RST = 1'b1; idle();
    @(negedge CLK); RST = 1'b0; drive(1'b0, '0, '0, 4'h0, 1'b1, 6'd0); model_reset();
    repeat (30) @(negedge CLK);
    #1;
    checks_total++; if ({CEN, A} !== {1'b0, 6'd30}) $display("FAIL midsweep_ptr: CEN=%b A=%0d want 0/30", CEN, A); else checks_passed++;
    RST = 1'b1; #1;
    checks_total++; if ({CEN, rd_gnt, rd_vld} !== 3'b100) $display("FAIL midsweep_rst: CEN/rd_gnt/rd_vld got %b want 100", {CEN, rd_gnt, rd_vld}); else checks_passed++;
    test_init_sweep();
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks_total = 0;
    checks_passed = 0;
    RST = 1'b1;
    idle();
    model_reset();
    test_reset();
    test_init_sweep();
    test_write_read();
    test_lane_mask();
    test_noop_write();
    test_contention();
    test_random(400);
    test_reset_mid_run();
`ifdef CT_SPSRAM_ARB_INIT_EN
    test_reset_mid_sweep();
`endif
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
